// File: rtl/pipeline_chain.sv
// pipeline_chain: a chain of STAGES valid/ready register slices with bubble
// collapsing, a synchronous flush and an occupancy count.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           synchronous clear of every held beat
//   in_valid/in_data/in_ready     upstream stream
//   out_valid/out_data/out_ready  downstream stream (driven by the last stage)
//   count           number of occupied slices
//
// Optional build macro PIPE_SKID_EN: adds a skid slice ahead of stage 0 so
// that in_ready comes from a flop instead of rippling back from out_ready.
// Capacity then becomes STAGES+1.
module pipeline_chain #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned CW     = $clog2(STAGES + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] rdy;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [CW-1:0]     count_q, count_d;

    logic              in_hs;
    logic              out_hs;
    logic              up_valid0;
    logic [WIDTH-1:0]  up_data0;

`ifdef PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0]  skid_data_q, skid_data_d;
`endif

    // A stage is ready when it, or any stage downstream of it, can make room.
    // Accumulated from the output end so each bit is computed exactly once.
    always_comb begin
        logic room;
        rdy  = '0;
        room = out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
            room          = room | ~valid_q[LAST - k];
            rdy[LAST - k] = room;
        end
    end

`ifdef PIPE_SKID_EN
    // in_ready depends only on the skid flop (and flush), never on out_ready.
    assign in_ready  = ~skid_valid_q & ~flush;
    assign in_hs     = in_valid & in_ready;
    // A parked beat always goes first; new input is refused while it is parked.
    assign up_valid0 = skid_valid_q | in_hs;
    assign up_data0  = skid_valid_q ? skid_data_q : in_data;
`else
    assign in_ready  = rdy[0] & ~flush;
    assign in_hs     = in_valid & in_ready;
    assign up_valid0 = in_hs;
    assign up_data0  = in_data;
`endif

    assign out_valid = valid_q[LAST] & ~flush;
    assign out_data  = data_q[LAST];
    assign out_hs    = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
`ifdef PIPE_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (rdy[0]) begin
                skid_valid_d = 1'b0;
            end
        end else if (in_hs && !rdy[0]) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
`endif

        if (up_valid0 && rdy[0]) begin
            valid_d[0] = 1'b1;
            data_d[0]  = up_data0;
        end else if (valid_q[0] && rdy[0]) begin
            valid_d[0] = 1'b0;
        end

        for (int unsigned i = 1; i < STAGES; i++) begin
            if (valid_q[i-1] && rdy[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = data_q[i-1];
            end else if (valid_q[i] && rdy[i]) begin
                valid_d[i] = 1'b0;
            end
        end

        case ({in_hs, out_hs})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Payload registers are left as they are; only occupancy is cleared.
        if (flush) begin
            valid_d = '0;
            count_d = '0;
`ifdef PIPE_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
`ifdef PIPE_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
`ifdef PIPE_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipeline_chain.sv
module tb_pipeline_chain;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 3;
    localparam int unsigned CW     = $clog2(STAGES + 2);
`ifdef PIPE_SKID_EN
    localparam int CAP  = STAGES + 1;
    localparam bit SKID = 1'b1;
`else
    localparam int CAP  = STAGES;
    localparam bit SKID = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    always #5 clk = ~clk;

    pipeline_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of accepted beats. Each beat becomes visible at
    // the output STAGES cycles after acceptance (one more if it had to park in
    // the skid slice), but never before the cycle after its predecessor left.
    logic [WIDTH-1:0] m_data[$];
    int               m_acc[$];
    int               m_park[$];
    logic [WIDTH-1:0] emitted[$];
    int               last_emit = -1000;
    int               cyc = 0;
    bit               chk_en = 1'b0;
    bit               e_ir = 1'b0;
    bit               e_ov = 1'b0;

    initial begin
        int head_t;
        forever begin
            @(negedge clk);
            e_ir = !flush && (m_data.size() < CAP || (!SKID && out_ready));
            e_ov = 1'b0;
            if (!flush && m_data.size() > 0) begin
                head_t = m_acc[0] + STAGES + m_park[0];
                if (last_emit + 1 > head_t) head_t = last_emit + 1;
                e_ov = (cyc >= head_t);
            end
            if (chk_en) begin
                check("in_ready", in_ready, e_ir);
                check("out_valid", out_valid, e_ov);
                check("count", count, m_data.size());
                if (e_ov) check("out_data", out_data, m_data[0]);
            end
        end
    end

    initial begin
        bit park;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_data.delete(); m_acc.delete(); m_park.delete();
                last_emit = -1000;
                chk_en = 1'b1;
            end else if (flush) begin
                m_data.delete(); m_acc.delete(); m_park.delete();
                last_emit = -1000;
            end else begin
                park = SKID && (m_data.size() == STAGES) && !out_ready;
                if (e_ov && out_ready) begin
                    emitted.push_back(m_data[0]);
                    void'(m_data.pop_front());
                    void'(m_acc.pop_front());
                    void'(m_park.pop_front());
                    last_emit = cyc;
                end
                if (e_ir && in_valid) begin
                    m_data.push_back(in_data);
                    m_acc.push_back(cyc);
                    m_park.push_back(park ? 1 : 0);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 'h55; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        #3;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);

        // Streaming
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            in_valid = 1'b1; in_data = k;
            #3;
            if (k == 4) begin
                check("stream_first_data", out_data, 1);
                check("stream_count", count, 3);
            end
            if (k == 10) check("stream_mid_data", out_data, 7);
        end
        tick(); in_valid = 1'b0;
        repeat (4) tick();
        check("stream_n_out", emitted.size(), 16);
        check("stream_last", emitted[15], 16);
        emitted.delete();

        // Backpressure
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            in_valid = (idx < 4); in_data = 'hA0 + idx; out_ready = (c >= 5);
            #3;
            if (c == 3) begin
                check("bp_count3", count, 3);
                check("bp_ready3", in_ready, SKID);
            end
            if (c == 4) begin
                check("bp_full_count", count, CAP);
                check("bp_full_ready", in_ready, 0);
            end
            if (c == 5) check("bp_first_out", out_data, 'hA0);
            if (in_valid && in_ready) idx++;
        end
        check("bp_n_out", emitted.size(), 4);
        for (int i = 0; i < 4; i++) check("bp_order", emitted[i], 'hA0 + i);
        check("bp_drained", count, 0);
        emitted.delete();

        // Bubble collapse
        out_ready = 1'b0;
        tick(); in_valid = 1'b1; in_data = 'hB0;
        tick(); in_valid = 1'b0;
        tick();
        tick(); in_valid = 1'b1; in_data = 'hB1;
        #3;
        check("bub_out_valid", out_valid, 1);
        check("bub_out_data", out_data, 'hB0);
        check("bub_count", count, 1);
        check("bub_in_ready", in_ready, 1);
        tick(); in_data = 'hB2;
        tick(); in_valid = 1'b0;
        #3;
        check("bub_full_count", count, 3);
        check("bub_full_ready", in_ready, SKID);

        // Full with simultaneous accept and emit
        for (int k = 0; k < 6; k++) begin
            tick();
            in_valid = 1'b1; in_data = 'hC0 + k; out_ready = 1'b1;
            #3;
            check("full_ready", in_ready, 1);
            check("full_count", count, 3);
        end
        tick(); in_valid = 1'b0;
        repeat (5) tick();
        check("full_n_out", emitted.size(), 9);
        check("full_b2", emitted[2], 'hB2);
        check("full_c0", emitted[3], 'hC0);
        check("full_c5", emitted[8], 'hC5);

        // Flush
        out_ready = 1'b0;
        tick(); in_valid = 1'b1; in_data = 'hD0;
        tick(); in_data = 'hD1;
        tick(); flush = 1'b1; in_data = 'hDD;
        #3;
        check("flush_count_before", count, 2);
        check("flush_in_ready", in_ready, 0);
        check("flush_out_valid", out_valid, 0);
        tick(); flush = 1'b0; in_valid = 1'b0;
        #3;
        check("flush_count_after", count, 0);
        check("flush_out_valid_after", out_valid, 0);
        out_ready = 1'b1;
        repeat (5) tick();
        check("flush_no_out", emitted.size(), 9);

        // Reset mid-stream
        out_ready = 1'b0;
        tick(); in_valid = 1'b1; in_data = 'hE0;
        tick(); in_data = 'hE1;
        tick(); in_valid = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        #3;
        check("mid_rst_count", count, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (5) tick();
        check("mid_rst_no_out", emitted.size(), 9);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_chain.md
Name: pipeline_chain

Overview:
- Parametrised successor to the single-stage valid/ready pipeline register: a chain of STAGES register slices with per-stage bubble collapsing.
- Sits between any two valid/ready streaming endpoints to add STAGES cycles of timing slack with no throughput loss.
- Adds what the single-stage block lacks: configurable depth, a synchronous flush, and an occupancy output.
- An optional input skid slice registers in_ready.

Parameters:
WIDTH, 32, payload width in bits (>=1)
STAGES, 3, number of register slices in the chain (>=1)
CW, $clog2(STAGES+2), width of the occupancy count (derived; sized for the skid build)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of all held beats
in_valid  in  1  upstream beat valid
in_data  in  WIDTH  upstream payload
in_ready  out  1  chain can accept a beat this cycle
out_valid  out  1  last stage holds a beat
out_data  out  WIDTH  last-stage payload
out_ready  in  1  downstream accepts
count  out  CW  number of occupied slices

Behaviour:
- One clock. Reset is synchronous and active-high: rst sampled high at a clk edge clears state at that edge.
- Reset values: every valid_q[i]=0 and data_q[i]=0. Hence out_valid=0, out_data=0, count=0, and in_ready=1 (when flush=0).
- Stage i holds valid_q[i] and data_q[i]. Stage 0 faces the input; stage STAGES-1 drives out_valid and out_data.
- Per-stage ready (combinational):
  - rdy[STAGES-1] = ~valid_q[STAGES-1] | out_ready
  - rdy[i] = ~valid_q[i] | rdy[i+1]
  - in_ready = rdy[0] & ~flush
- Transfer into stage i occurs when its upstream valid and rdy[i] are both high. The upstream valid is in_valid for stage 0 and valid_q[i-1] otherwise.
  - On transfer: data_q[i] <= upstream data; valid_q[i] <= 1.
  - Else, if the stage's beat leaves (valid_q[i] & rdy[i]): valid_q[i] <= 0. data_q[i] is held.
  - Else: hold.
- Bubble collapse: a beat advances whenever the next slice is empty or draining, independently of other stalls.
- Latency: an accepted beat reaches out_valid exactly STAGES cycles after acceptance when unstalled. Throughput is 1 beat/cycle sustained.
- Full condition: all valid_q=1 and out_ready=0 -> in_ready=0. No beat is lost or duplicated.
- Simultaneous accept and emit when full: allowed. in_ready=1 when out_ready=1, and count is unchanged.
- count:
  - +1 on an input handshake without an output handshake.
  - -1 on an output handshake without an input handshake.
  - Otherwise unchanged.
  - Range 0..STAGES.
- Ordering: beats emerge in acceptance order. Payload is never modified.
- out_data is held stable while out_valid=1 and out_ready=0.
- flush (synchronous):
  - During the flush cycle: in_ready=0 and out_valid is forced 0, so no handshakes occur.
  - At the edge: all valid_q clear and count becomes 0. data_q may keep its old contents.
- rst has priority over flush. Reset mid-stream discards all beats with no output handshake.

Optional Feature:
Macro: PIPE_SKID_EN
- Defined:
  - Adds one skid slice ahead of stage 0, so capacity is STAGES+1.
  - in_ready is driven directly from a flop (~skid_valid & ~flush_q style, no combinational path from out_ready).
  - A beat that arrives while rdy[0]=0 parks in the skid slice. It drains into stage 0 before any new input.
  - count includes the skid slice, range 0..STAGES+1.
  - Latency is unchanged when unstalled: beats bypass the empty skid slice.
- Undefined: in_ready is the combinational ripple above, and capacity is STAGES.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, count=0, in_ready=1 after release. No beat is captured during reset.
- Streaming: STAGES=3, out_ready=1, in_data=0x1,0x2,...,0x10 on consecutive cycles -> out_data 0x1 appears 3 cycles after its accept, then one beat per cycle in order, count steady at 3.
- Backpressure: out_ready=0, push 0xA0..0xA3 -> 3 accepted (count=3), 0xA3 refused (in_ready=0). Raise out_ready -> 0xA0,0xA1,0xA2 emitted in order, then 0xA3 accepted.
- Bubble collapse: load 0xB0 only, hold out_ready=0 -> beat reaches last stage after 3 cycles, count=1, in_ready=1. Push 0xB1, 0xB2 -> count=3.
- Full simultaneous: full with out_ready=1 and in_valid=1 every cycle -> in_ready=1, count stays 3, no drop.
- Flush: count=2, pulse flush with in_valid=1 -> in_ready=0 and out_valid=0 that cycle. Next cycle count=0 and the offered beat was not taken. With PIPE_SKID_EN, repeat the backpressure case -> 4 beats accepted, in_ready rises one cycle after the first drain.
